// File: rtl/jpeg_bitstream_feeder.sv
// jpeg_bitstream_feeder: packs scan bytes into bit-reversed BUS_W words, buffers them, pads with all-ones after end of scan.
// Optional marker stripping (FF00 unstuff, RSTn drop, EOI end) is enabled by defining JPEG_FEEDER_STUFF_STRIP_EN.
module jpeg_bitstream_feeder #(
  parameter int BUS_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       byte_data_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  input  logic             byte_last_i,
  input  logic             request_i,
  output logic [BUS_W-1:0] data_in_o,
  output logic             valid_in_o,
  output logic             done_o,
  output logic             stuff_err_o,
  output logic [31:0]      words_sent_o
);
  localparam int NB = BUS_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_PAD    = 3'd4;

  logic [2:0]       st_q, st_d;
  logic [BUS_W-1:0] pk_q, pk_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BUS_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      fc_q;
  logic [BUS_W-1:0] data_q;
  logic             valid_q;
  logic [31:0]      ws_q;
  logic             full, empty, acc, pack_v, end_scan, push, pop, pad_pop;
  logic [7:0]       pack_b;
  logic [BUS_W-1:0] push_w;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int j = 0; j < 8; j++) rev8[j] = b[7-j];
  endfunction

  assign full         = fc_q == (AW+1)'(FIFO_DEPTH);
  assign empty        = fc_q == '0;
  assign byte_ready_o = (st_q == S_ACTIVE) && !full;
  assign acc          = byte_valid_i && byte_ready_o && !start_i;
  assign pop          = !start_i && request_i && !empty;
  assign pad_pop      = !start_i && request_i && empty && (st_q == S_PAD);
  assign data_in_o    = data_q;
  assign valid_in_o   = valid_q;
  assign done_o       = st_q == S_PAD;
  assign words_sent_o = ws_q;

`ifdef JPEG_FEEDER_STUFF_STRIP_EN
  logic pend_q, pend_d, err_q, err_d;
  // An FF is held back until its successor shows whether it is data or a marker.
  always_comb begin
    pack_v   = 1'b0;
    pack_b   = byte_data_i;
    end_scan = 1'b0;
    pend_d   = pend_q;
    err_d    = err_q;
    if (acc && !pend_q) begin
      pend_d   = (byte_data_i == 8'hFF) && !byte_last_i;
      pack_v   = !pend_d;
      end_scan = byte_last_i;
    end else if (acc) begin
      pend_d   = 1'b0;
      pack_v   = byte_data_i == 8'h00;
      pack_b   = 8'hFF;
      end_scan = byte_last_i || (byte_data_i == 8'hD9);
      err_d    = err_q || !(pack_v || byte_data_i[7:3] == 5'b11010 || byte_data_i == 8'hD9);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= start_i ? 1'b0 : pend_d;
      err_q  <= start_i ? 1'b0 : err_d;
    end
  end
  assign stuff_err_o = err_q;
`else
  assign pack_v      = acc;
  assign pack_b      = byte_data_i;
  assign end_scan    = acc && byte_last_i;
  assign stuff_err_o = 1'b0;
`endif

  // Empty lanes rest at all-ones so a flushed partial word is already padded.
  always_comb begin
    st_d   = st_q;
    pk_d   = pk_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    push_w = pk_q;
    if (pack_v) begin
      pk_d[8*cnt_q +: 8] = rev8(pack_b);
      push   = cnt_q == CW'(NB-1);
      push_w = pk_d;
      cnt_d  = push ? '0 : cnt_q + 1'b1;
      pk_d   = push ? '1 : pk_d;
    end
    case (st_q)
      S_ACTIVE: st_d = end_scan ? S_FLUSH : S_ACTIVE;
      S_FLUSH: begin
        if (cnt_q == '0) begin
          st_d = S_DRAIN;
        end else if (!full) begin
          push   = 1'b1;
          push_w = pk_q;
          pk_d   = '1;
          cnt_d  = '0;
          st_d   = S_DRAIN;
        end
      end
      S_DRAIN: st_d = empty ? S_PAD : S_DRAIN;
      default: st_d = st_q;
    endcase
    if (start_i) begin
      st_d  = S_ACTIVE;
      pk_d  = '1;
      cnt_d = '0;
      push  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q  <= S_IDLE;
      pk_q  <= '1;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      pk_q  <= pk_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= push_w;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
    end else if (start_i) begin
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
    end else begin
      wp_q <= push ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      fc_q <= fc_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ws_q    <= '0;
    end else begin
      valid_q <= pop || pad_pop;
      data_q  <= pop ? mem_q[rp_q] : (pad_pop ? '1 : data_q);
      ws_q    <= start_i ? '0 : ws_q + {31'd0, pop};
    end
  end
endmodule

// File: doc/jpeg_bitstream_feeder.md
Name: jpeg_bitstream_feeder

Overview:
- Producer end of the decoder's `request`/`data_in`/`valid_in` input interface.
- Accepts the entropy-coded scan as a byte stream from a DMA/memory reader and packs the bytes into BUS_W-bit words in the decoder's bit-reversed ("flipped") order.
- Buffers the words in a small FIFO and hands one word to `jpeg_decoder_top` for each request cycle.
- After end of scan, supplies all-ones pad words so the decoder can drain its final blocks.

Parameters:
- BUS_W, 32: output word width. Must equal `IN_BUS_WIDTH`, be a multiple of 8, and be ≥8.
- FIFO_DEPTH, 4: word FIFO depth. Power of 2, ≥2.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new scan. Clears done, stuff_err, words_sent, packer and FIFO.
- byte_data  in  8  scan byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  feeder accepts the byte this cycle.
- byte_last  in  1  qualifies the final scan byte.
- request  in  1  decoder wants a word (level).
- data_in  out  BUS_W  word to decoder.
- valid_in  out  1  data_in is valid this cycle.
- done  out  1  scan fully packed and all real words delivered.
- stuff_err  out  1  sticky illegal-marker flag.
- words_sent  out  32  count of real (non-pad) words delivered.

Behaviour:
- Reset values: byte_ready=0, data_in=0, valid_in=0, done=0, stuff_err=0, words_sent=0. State is IDLE, FIFO empty, packer empty.
- Reset mid-scan discards everything. No word is emitted after reset until start.
- States:
  - IDLE: byte_ready=0. start → ACTIVE.
  - ACTIVE: byte accepted when byte_valid && byte_ready, where byte_ready=1 iff the FIFO is not full. Accepting byte_last → FLUSH.
  - FLUSH: packer holds k bytes. k=0: nothing is pushed. 0<k<BUS_W/8: unused byte lanes are filled with 8'hFF and one word is pushed (one cycle, waits if FIFO full). Then → DRAIN.
  - DRAIN: byte_ready=0. When the FIFO is empty, done=1 → PAD.
  - PAD: done stays 1. Each request cycle yields an all-ones word; words_sent is not incremented. start → ACTIVE.
- start in any state restarts. A start coincident with an accepted byte drops that byte.
- Packing:
  - Byte i of a word (0 = first received) occupies bits [8i+7:8i], bit-reversed.
  - The MSB of the first byte lands at data_in[0]; the full word equals the 32-bit bit-reversal of the MSB-first concatenation.
  - A full word is pushed in the same cycle its last byte is accepted.
- Output handshake:
  - Sampled on the rising edge: if request=1 and a word is available (FIFO non-empty, or state PAD), the word is popped and registered. Next cycle valid_in=1, data_in=word, and words_sent increments for real words.
  - Otherwise valid_in=0 next cycle and data_in holds its last value.
  - One word per request-high cycle. Latency is 1 cycle from request to valid_in.
  - Request held high with a non-empty FIFO gives back-to-back valid_in.
- FIFO:
  - Push and pop in the same cycle at full are both allowed; occupancy is unchanged.
  - Push at full cannot occur (byte_ready gating).
  - Pop at empty never occurs outside PAD.
- words_sent wraps at 2^32.

Optional Feature:
- Macro: JPEG_FEEDER_STUFF_STRIP_EN.
- Defined:
  - Marker parser sits ahead of the packer.
  - FF 00 → single FF.
  - FF D0–D7 (RSTn) → both bytes dropped.
  - FF D9 (EOI) → treated as byte_last on the preceding byte (EOI not packed).
  - FF followed by any other value → stuff_err set, both bytes dropped.
  - A trailing FF with byte_last is packed as-is.
  - A pending FF is held across cycles without stalling.
- Undefined: all bytes pass verbatim, end of scan only via byte_last, stuff_err tied 0.

Test Plan:
- Basic pack (BUS_W=32): start, bytes 12 34 56 78, byte_last on 78, request high → one valid_in with data_in=32'h1E6A2C48. words_sent=1, done=1 next cycle, subsequent words 32'hFFFFFFFF with words_sent still 1.
- Partial flush: bytes AB (last) → data_in=32'hFFFFFFD5, words_sent=1.
- Backpressure: request low, stream 24 bytes with FIFO_DEPTH=4 → byte_ready drops after 16 bytes. Then request held high → 6 consecutive valid_in cycles, no loss or reorder.
- Stuffing (macro on): FF 00 12 34 56 (last) → data_in=32'h6A2C48FF, stuff_err=0. FF 05 in stream → stuff_err=1 sticky until start.
- EOI (macro on): 12 34 56 FF D9 with no byte_last → data_in=32'hFF6A2C48, done=1.
- Async reset mid-scan: rst=0 after 3 bytes → all outputs 0 immediately. Then start and bytes 12 34 56 78 (last) → data_in=32'h1E6A2C48, words_sent=1.
